// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sort_pkg
//  Description : Shared types and key comparison for the sort engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package sort_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_RD0   = 3'd2,
    S_LOAD  = 3'd3,
    S_RUN   = 3'd4,
    S_FLUSH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Widest key the comparator handles; callers zero-extend into this width.
  localparam int unsigned CMP_W = 64;

  // True when a (earlier) and b (later) must swap. Signed keys are compared
  // by flipping the sign bit, which maps two's complement order onto
  // unsigned order. Equal keys never swap, which keeps the sort stable.
  function automatic logic out_of_order(
    input logic [CMP_W-1:0] a,
    input logic [CMP_W-1:0] b,
    input int unsigned      width,
    input logic             desc,
    input logic             is_signed
  );
    logic [CMP_W-1:0] bias;
    logic [CMP_W-1:0] ka;
    logic [CMP_W-1:0] kb;
    bias = {{(CMP_W-1){1'b0}}, is_signed} << (width - 1);
    ka   = a ^ bias;
    kb   = b ^ bias;
    return desc ? (ka < kb) : (ka > kb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sort_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sort_ram
//  Description : DEPTH x DATA_WIDTH storage, one synchronous read port and
//                one write port. Contents are never cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sort_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] memory [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_wr_en) memory[i_waddr] <= i_wdata;
  end

  // Registered read port; only the output register is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= memory[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sort_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sort_engine
//  Description : In-place early-exit bubble sort over a window of the
//                internal RAM; host owns the RAM ports while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sort_engine
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  order_valid,
  input  logic [ADDR_WIDTH-1:0] order_start,
  input  logic [ADDR_WIDTH:0]   order_len,
  input  logic                  order_desc,
  output logic                  order_busy,
  output logic                  order_done,
  output logic                  order_err,
  output logic [ADDR_WIDTH:0]   pass_count,
  input  logic                  mem_wr_en,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH+1:0] c_DEPTH_EXT = {2'b01, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] c_ONE_A     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   c_ONE_L     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   c_TWO_L     = {{(ADDR_WIDTH-1){1'b0}}, 2'b10};
  localparam logic                  c_IS_SIGNED = (SIGNED != 0);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_start;
  logic [ADDR_WIDTH:0]   r_len;
  logic                  r_desc;
  logic [ADDR_WIDTH:0]   r_m;
  logic [ADDR_WIDTH-1:0] r_k;
  logic [DATA_WIDTH-1:0] r_held;
  logic                  r_swap;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [ADDR_WIDTH:0]   r_pass;

  logic [DATA_WIDTH-1:0] w_rdata;
  logic [ADDR_WIDTH-1:0] w_last;
  logic [ADDR_WIDTH+1:0] w_end;
  logic                  w_oob;
  logic                  w_swap_now;
  logic                  w_eng_we;
  logic [ADDR_WIDTH-1:0] w_eng_waddr;
  logic [DATA_WIDTH-1:0] w_eng_wdata;
  logic [ADDR_WIDTH-1:0] w_eng_raddr;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_waddr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [ADDR_WIDTH-1:0] w_ram_raddr;

  // Window end is computed two bits wider so start+len cannot wrap.
  assign w_last = r_start + r_m[ADDR_WIDTH-1:0] - c_ONE_A;
  assign w_end  = {2'b00, r_start} + {1'b0, r_len};
  assign w_oob  = (w_end > c_DEPTH_EXT);

  assign w_swap_now = out_of_order({{(CMP_W-DATA_WIDTH){1'b0}}, r_held},
                                   {{(CMP_W-DATA_WIDTH){1'b0}}, w_rdata},
                                   DATA_WIDTH, r_desc, c_IS_SIGNED);

  // Engine-side RAM access decoded from the current state.
  always_comb begin
    w_eng_we    = 1'b0;
    w_eng_waddr = r_k - c_ONE_A;
    w_eng_wdata = w_swap_now ? w_rdata : r_held;
    w_eng_raddr = r_k + c_ONE_A;
    case (r_state)
      S_RD0:   w_eng_raddr = r_start;
      S_LOAD:  w_eng_raddr = r_start + c_ONE_A;
      S_RUN:   w_eng_we    = 1'b1;
      S_FLUSH: begin
        w_eng_we    = 1'b1;
        w_eng_waddr = w_last;
        w_eng_wdata = r_held;
      end
      default: ;
    endcase
  end

  // Host owns the RAM while idle; its writes are dropped while busy.
  assign w_ram_we    = r_busy ? w_eng_we    : mem_wr_en;
  assign w_ram_waddr = r_busy ? w_eng_waddr : mem_addr;
  assign w_ram_wdata = r_busy ? w_eng_wdata : mem_wdata;
  assign w_ram_raddr = r_busy ? w_eng_raddr : mem_addr;

  sort_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_wr_en (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_rdata)
  );

  // Sort sequencer: one pass is RD0, LOAD, RUN per element, FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_start <= '0;
      r_len   <= '0;
      r_desc  <= 1'b0;
      r_m     <= '0;
      r_k     <= '0;
      r_held  <= '0;
      r_swap  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_pass  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (order_valid) begin
            r_start <= order_start;
            r_len   <= order_len;
            r_desc  <= order_desc;
            r_pass  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_len < c_TWO_L) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_oob) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_m     <= r_len;
            r_state <= S_RD0;
          end
        end
        S_RD0: begin
          r_swap  <= 1'b0;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_held  <= w_rdata;
          r_k     <= r_start + c_ONE_A;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_swap_now) r_swap <= 1'b1;
          else            r_held <= w_rdata;
          if (r_k == w_last) r_state <= S_FLUSH;
          else               r_k     <= r_k + c_ONE_A;
        end
        S_FLUSH: begin
          r_pass <= r_pass + c_ONE_L;
          if (!r_swap || (r_m == c_TWO_L)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_m     <= r_m - c_ONE_L;
            r_state <= S_RD0;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign order_busy = r_busy;
  assign order_done = r_done;
  assign order_err  = r_err;
  assign pass_count = r_pass;
  assign mem_rdata  = w_rdata;

endmodule
`default_nettype wire

// File: doc/sort_engine.md
# sort_engine

Parametrised successor to the single-mode sort system: sorts a contiguous window of an internal memory in place using early-exit bubble sort, with selectable ascending/descending order and signed/unsigned keys. It also reports errors for out-of-range windows, pulses a done flag, and gives the host a load/readback port while idle. It sits between a host controller, which loads data and issues orders, and the internal RAM sub-module.

## Interface
- DATA_WIDTH, 16, element width in bits
- ADDR_WIDTH, 8, address width; memory depth DEPTH = 2**ADDR_WIDTH
- SIGNED, 0, 1 = compare as two's complement, 0 = unsigned
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- order_valid  in  1  order request; accepted when order_valid && !order_busy
- order_start  in  ADDR_WIDTH  first address of window
- order_len  in  ADDR_WIDTH+1  element count (0..DEPTH)
- order_desc  in  1  1 = descending, 0 = ascending; sampled at accept
- order_busy  out  1  engine running; reset 0
- order_done  out  1  one-cycle completion pulse; reset 0
- order_err  out  1  one-cycle error pulse coincident with order_done; reset 0
- pass_count  out  ADDR_WIDTH+1  passes executed by last order; reset 0
- mem_wr_en  in  1  host write strobe; ignored while busy
- mem_addr  in  ADDR_WIDTH  host address
- mem_wdata  in  DATA_WIDTH  host write data
- mem_rdata  out  DATA_WIDTH  RAM read data, 1-cycle latency; reset 0; undefined while busy

## Operation
- FSM states: IDLE, CHECK, RD0, LOAD, RUN, FLUSH, DONE.
- IDLE: on accept, latch start, len, desc; clear pass_count; go to CHECK.
- CHECK:
  - len < 2: go to DONE, no error.
  - start + len > DEPTH (computed at ADDR_WIDTH+2 bits, no wrap): go to DONE with err set.
  - Otherwise set m = len, go to RD0.
- Each pass works over addresses start..start+m-1:
  - RD0: issue read start; clear swap flag.
  - LOAD: capture held = mem[start]; issue read start+1; k = start+1.
  - RUN, one cycle per k:
    - new = rdata.
    - If out_of_order(held, new), write new to k-1, keep held, set swap flag.
    - Else write held to k-1 and set held = new.
    - Issue read k+1.
    - Leave RUN after k = start+m-1.
  - FLUSH: write held to start+m-1; pass_count++.
    - If swap flag = 0 or m = 2, go to DONE.
    - Else m = m-1 and go to RD0.
- out_of_order: ascending means held > new; descending means held < new. Signedness per SIGNED. Equal keys never swap, so the sort is stable.
- DONE: order_done = 1; order_err as latched; go to IDLE.
- Orders presented while busy are ignored and not queued. Host writes while busy are dropped.
- The read of k+1 and the write of k-1 in the same cycle never alias (RAM has separate read and write ports).

## Timing
- Accept at edge N: order_busy = 1 from N+1 through the DONE cycle; 0 the cycle after.
- len < 2 or error: CHECK at N+1, DONE at N+2 (busy for 2 cycles); no RAM writes.
- Pass over m elements: RD0 + LOAD + (m-1) RUN + FLUSH = m+2 cycles.
- Total busy = 1 (CHECK) + Σ(m_i+2) + 1 (DONE).
- Already-sorted input of length L: exactly one pass, busy = L+4 cycles, pass_count = 1.
- Worst case: L-1 passes.
- rst asserted at any time, including mid-sort:
  - FSM returns to IDLE; all outputs take their reset values.
  - RAM contents are not cleared. A partially sorted window is a legal result.
- order_valid asserted in the DONE cycle is ignored (busy still 1); it is accepted the next cycle.

## Structure
- Package sort_pkg holds:
  - state_t enum (the seven states).
  - A parametrised compare function (a, b, desc, signed) returning out_of_order.
- Sub-module sort_ram holds:
  - DEPTH × DATA_WIDTH storage.
  - 1 synchronous read port and 1 write port.
  - Array named memory, for bench backdoor preload and dump.
- The read/write ports are muxed between host and engine on order_busy.

## Test plan
- Host loads {1,2,5,1,3,7,5} at addr 0; order start 0, len 7, asc → memory {1,1,2,3,5,5,7}, done pulse, err 0.
- Same data, desc, SIGNED=1 with {3,-2,7,0} at start 10, len 4 → {7,3,0,-2}; addresses 9 and 14 unchanged.
- Sorted {1,2,3,4,5}, len 5 → busy exactly 9 cycles, pass_count 1, no data change.
- start DEPTH-2, len 3 → busy 2 cycles, order_err and order_done pulse together, memory untouched. len 0 and len 1 → done, no err.
- Second order_valid and mem_wr_en during busy → ignored, result identical to single-order run.
- rst pulse mid-sort → busy/done/err/pass_count 0 immediately; a new order then completes correctly.
